multi_op_restorer: RTL and testbench

//  Inverse of the multi-op processor: takes a processed byte plus the op code that produced it
//  and reconstructs the original operand.

---
 rtl/multi_op_pkg.sv | 17 +
 rtl/restorer_fifo.sv | 61 ++++++
 rtl/multi_op_restorer.sv | 83 ++++++++
 tb/tb_multi_op_restorer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/multi_op_pkg.sv
// Shared op encoding for the multi-op processor and its restorer.
// Also holds the one rule deciding whether a processed beat is impossible.
package multi_op_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_INC = 2'b00;
  localparam op_t OP_DEC = 2'b01;
  localparam op_t OP_NOT = 2'b10;
  localparam op_t OP_SHL = 2'b11;

  // A left shift always clears the LSB, so an odd shl result is bogus.
  function automatic logic shl_err(op_t op, logic lsb);
    return (op == OP_SHL) && lsb;
  endfunction

endpackage

// File: rtl/restorer_fifo.sv
// Generic synchronous FIFO with registered storage.
// Head word drives rdata_o directly, so it holds while not popped.
module restorer_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [AW:0]      count_q;
  logic [AW:0]      count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= wdata_i;
        wptr_q        <= wptr_q + AW'(1);
      end
      if (do_pop) rptr_q <= rptr_q + AW'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/multi_op_restorer.sv
// Undoes a multi-op processor beat and queues the original operand.
// Impossible shl results are flagged, delivered anyway, and counted.
module multi_op_restorer
  import multi_op_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int ERR_CW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  op_t               in_op,
  input  logic              in_msb,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output op_t               out_op,
  output logic              out_err,
  output logic [ERR_CW-1:0] err_count
);

  localparam int FW = DATA_W + 3;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] restored;
  logic              err;
  logic              accept;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [FW-1:0]     fifo_rdata;
  logic [ERR_CW-1:0] err_cnt_q;
  logic [ERR_CW-1:0] err_cnt_d;

  always_comb begin
    restored = in_data;
    unique case (in_op)
      OP_INC: restored = in_data - DATA_W'(1);
      OP_DEC: restored = in_data + DATA_W'(1);
      OP_NOT: restored = ~in_data;
      OP_SHL: restored = {in_msb, in_data[DATA_W-1:1]};
    endcase
  end

  assign err    = shl_err(in_op, in_data[0]);
  assign accept = in_valid && in_ready;

  assign in_ready  = !fifo_full;
  assign out_valid = (fifo_count != '0);
  assign {out_err, out_op, out_data} = fifo_rdata;

  restorer_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (accept),
    .wdata_i ({err, in_op, restored}),
    .pop_i   (out_ready && !fifo_empty),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (accept && err && (err_cnt_q != '1))
      err_cnt_d = err_cnt_q + ERR_CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_multi_op_restorer.sv
// Randomized + directed bench for multi_op_restorer.
// Reference model: arithmetic inverse + queue of expected beats.
module tb_multi_op_restorer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic [1:0] in_op = '0;
  logic       in_msb = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic [1:0] out_op;
  logic       out_err;
  logic [7:0] err_count;

  typedef struct {
    int data;
    int op;
    int err;
  } beat_t;

  beat_t q[$];
  int    errs = 0;
  int    total = 0;
  int    bad = 0;

  always #5 clk = ~clk;

  multi_op_restorer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_op     (in_op),
    .in_msb    (in_msb),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_op    (out_op),
    .out_err   (out_err),
    .err_count (err_count)
  );

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int restore(int d, int op, int msb);
    case (op)
      0:       return (d + 255) % 256;
      1:       return (d + 1) % 256;
      2:       return 255 - d;
      default: return msb * 128 + d / 2;
    endcase
  endfunction

  // Called at a negedge: check outputs, drive one cycle, return at next negedge.
  task automatic step(input bit v, input int d, input int op,
                      input int msb, input bit rdy);
    bit acc;
    bit pop;
    beat_t b;
    check("in_ready", in_ready, q.size() < 4);
    check("out_valid", out_valid, q.size() != 0);
    check("err_count", err_count, errs);
    if (q.size() != 0) begin
      check("out_data", out_data, q[0].data);
      check("out_op", out_op, q[0].op);
      check("out_err", out_err, q[0].err);
    end
    in_valid  = v;
    in_data   = d[7:0];
    in_op     = op[1:0];
    in_msb    = msb[0];
    out_ready = rdy;
    acc = v && (q.size() < 4);
    pop = rdy && (q.size() != 0);
    if (pop) void'(q.pop_front());
    if (acc) begin
      b.data = restore(d, op, msb);
      b.op   = op;
      b.err  = (op == 3 && d % 2 == 1) ? 1 : 0;
      q.push_back(b);
      if (b.err == 1 && errs < 255) errs++;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1);
    check("drained", out_valid, 0);
  endtask

  initial begin
    int x;
    int op;
    int fd;
    int fm;
    beat_t b;

    #2;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_op", out_op, 0);
    check("rst_err", out_err, 0);
    check("rst_ecnt", err_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", in_ready, 1);

    step(1, 8'h00, 0, 0, 0);
    check("t1_lat", out_valid, 1);
    check("t1_data", out_data, 8'hFF);
    check("t1_err", out_err, 0);
    drain();

    step(1, 8'h54, 3, 1, 0);
    check("t2_data", out_data, 8'hAA);
    check("t2_err", out_err, 0);
    drain();
    step(1, 8'h55, 3, 0, 0);
    check("t2_err1", out_err, 1);
    check("t2_ecnt", err_count, 1);
    drain();

    step(1, 8'hFF, 1, 0, 0);
    step(1, 8'h0F, 2, 0, 0);
    for (int i = 0; i < 3; i++) begin
      check("t3_hold_v", out_valid, 1);
      check("t3_hold_d", out_data, 8'h00);
      check("t3_hold_o", out_op, 1);
      step(0, 0, 0, 0, 0);
    end
    step(0, 0, 0, 0, 1);
    check("t3_second", out_data, 8'hF0);
    drain();

    for (int i = 0; i < 4; i++) step(1, 16 + i, 1, 0, 0);
    check("t4_full", in_ready, 0);
    step(1, 8'h77, 0, 0, 0);
    check("t4_held", in_ready, 0);
    check("t4_head", out_data, 8'h11);
    step(1, 8'h77, 0, 0, 1);
    check("t4_reopen", in_ready, 1);
    drain();

    for (int n = 0; n < 100; ) begin
      bit v;
      v  = ($urandom_range(0, 3) != 0);
      x  = $urandom_range(0, 255);
      op = $urandom_range(0, 3);
      case (op)
        0: fd = (x + 1) % 256;
        1: fd = (x + 255) % 256;
        2: fd = 255 - x;
        default: fd = (x * 2) % 256;
      endcase
      fm = x / 128;
      if ($urandom_range(0, 9) == 0) begin
        op = 3;
        fd = $urandom_range(0, 127) * 2 + 1;
      end
      if (v && q.size() < 4) begin
        n++;
        if (!(op == 3 && fd % 2 == 1)) begin
          b.data = restore(fd, op, fm);
          check("fwd_rt", b.data, x);
        end
      end
      step(v, fd, op, fm, $urandom_range(0, 1) == 1);
    end

    step(1, 8'h31, 3, 0, 0);
    step(1, 8'h22, 0, 0, 0);
    step(1, 8'h33, 2, 0, 0);
    check("t6_pre", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_valid", out_valid, 0);
    check("t6_ecnt", err_count, 0);
    check("t6_data", out_data, 0);
    q.delete();
    errs = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_ready", in_ready, 1);
    step(1, 8'h10, 2, 0, 0);
    check("t6_post", out_data, 8'hEF);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
